// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader takes the slave view; the host/memory side takes the master view.
interface imem_loader_if #(
  parameter int AW         = 12,
  parameter int BYTE_WIDTH = 8
);
  logic                  in_valid;
  logic [BYTE_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [BYTE_WIDTH-1:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: streams bytes into the instruction memory from base_addr,
// stalls fetch with a NOP while loading and keeps a running 8-bit checksum.
module imem_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    BYTE_WIDTH = 8,
  parameter int                    MEM_BYTES  = 4096,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013,
  parameter int                    AW         = $clog2(MEM_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [AW-1:0]         base_addr_i,
  input  logic [AW:0]           load_len_i,
  imem_loader_if.slave          bus,
  input  logic [ADDR_WIDTH-1:0] cpu_pc_i,
  output logic [ADDR_WIDTH-1:0] mem_raddr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] cpu_instr_o,
  output logic                  cpu_stall_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [BYTE_WIDTH-1:0] checksum_o
);

  localparam int          LW      = AW + 1;
  localparam logic [AW:0] MAX_LEN = LW'(MEM_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE_LAST,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         base_q, base_d;
  logic [AW:0]           len_q, len_d;
  logic [AW:0]           count_q, count_d;
  logic [BYTE_WIDTH-1:0] csum_q, csum_d;
  logic                  we_q, we_d;
  logic [AW-1:0]         waddr_q, waddr_d;
  logic [BYTE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  hs;

  assign hs = bus.in_valid && (state_q == S_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    count_d = count_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (load_len_i > MAX_LEN) begin
            err_d = 1'b1;
          end else begin
            base_d  = base_addr_i;
            len_d   = load_len_i;
            count_d = '0;
            csum_d  = '0;
            state_d = (load_len_i == '0) ? S_DONE : S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (hs) begin
          // address wraps naturally at the AW-bit boundary
          we_d    = 1'b1;
          waddr_d = base_q + count_q[AW-1:0];
          wdata_d = bus.in_data;
          count_d = count_q + 1'b1;
          csum_d  = csum_q + bus.in_data;
          if (count_d == len_q) state_d = S_WRITE_LAST;
        end
      end
      S_WRITE_LAST: state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.mem_we    = we_q;
  assign bus.mem_waddr = waddr_q;
  assign bus.mem_wdata = wdata_q;

  assign busy_o      = (state_q == S_LOAD) || (state_q == S_WRITE_LAST);
  assign cpu_stall_o = busy_o;
  assign done_o      = (state_q == S_DONE);
  assign err_o       = err_q;
  assign checksum_o  = csum_q;

  assign mem_raddr_o = cpu_pc_i;
  assign cpu_instr_o = busy_o ? NOP_INSTR : mem_rdata_i;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader: expected writes, done checksums
// and err pulses are queued at stimulus time and consumed by a negedge monitor.
module tb_imem_loader;
  localparam int          AW  = 12;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [7:0] csum;
    bit         wr;
  } dn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [12:0] load_len = '0;
  logic [31:0] cpu_pc = '0;
  logic [31:0] mem_rdata;
  logic [31:0] mem_raddr;
  logic [31:0] cpu_instr;
  logic        cpu_stall, busy, done, err;
  logic [7:0]  checksum;
  logic        mem_init = 1'b0;

  logic [7:0]  tb_mem  [4096];
  logic [7:0]  ref_mem [4096];
  logic [7:0]  stim[$];
  wr_t         exp_w[$];
  dn_t         exp_done[$];
  int          exp_err = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_we_cyc = -10;
  int          done_cnt = 0;

  always #5 clk = ~clk;

  imem_loader_if #(.AW(AW), .BYTE_WIDTH(8)) bus ();

  imem_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .base_addr_i (base_addr),
    .load_len_i  (load_len),
    .bus         (bus),
    .cpu_pc_i    (cpu_pc),
    .mem_raddr_o (mem_raddr),
    .mem_rdata_i (mem_rdata),
    .cpu_instr_o (cpu_instr),
    .cpu_stall_o (cpu_stall),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .checksum_o  (checksum)
  );

  // behavioural instruction memory behind the write port
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) tb_mem[i] <= '0;
    end else if (bus.mem_we) begin
      tb_mem[bus.mem_waddr] <= bus.mem_wdata;
    end
  end

  always_comb begin
    logic [11:0] a;
    a = cpu_pc[11:0];
    mem_rdata = {tb_mem[a + 12'd3], tb_mem[a + 12'd2], tb_mem[a + 12'd1], tb_mem[a]};
  end

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void fail_event(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event expected none (t=%0t)", nm, $time);
  endfunction

  function automatic logic [31:0] exp_word(logic [31:0] pc);
    logic [11:0] a;
    a = pc[11:0];
    return {ref_mem[a + 12'd3], ref_mem[a + 12'd2], ref_mem[a + 12'd1], ref_mem[a]};
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus.mem_we) begin
        if (exp_w.size() == 0) begin
          fail_event("unexpected_write");
        end else begin
          wr_t w;
          w = exp_w.pop_front();
          check("waddr", 32'(bus.mem_waddr), 32'(w.addr));
          check("wdata", 32'(bus.mem_wdata), 32'(w.data));
        end
        last_we_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          fail_event("unexpected_done");
        end else begin
          dn_t d;
          d = exp_done.pop_front();
          check("done_checksum", 32'(checksum), 32'(d.csum));
          if (d.wr) check("done_after_last_write", 32'(cyc), 32'(last_we_cyc + 1));
        end
      end
      if (err) begin
        if (exp_err == 0) fail_event("unexpected_err");
        else exp_err--;
      end
      check("raddr_passthru", mem_raddr, cpu_pc);
      check("stall_eq_busy", 32'(cpu_stall), 32'(busy));
    end
  end

  task automatic do_start(input logic [11:0] b, input int len);
    start = 1'b1;
    base_addr = b;
    load_len = 13'(len);
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 12'($urandom);
    load_len = 13'($urandom);
  endtask

  task automatic send_bytes(input int n, input bit alt, input int pct);
    int i = 0;
    int t = 0;
    bit v;
    while (i < n && t < 20000) begin
      v = alt ? (t % 2 == 0) : ($urandom_range(99) < pct);
      bus.in_valid = v;
      bus.in_data = v ? stim[i] : 8'($urandom);
      cpu_pc = $urandom;
      #1;
      check("in_ready_in_load", 32'(bus.in_ready), 32'd1);
      check("nop_while_busy", cpu_instr, NOP);
      check("stall_while_loading", 32'(cpu_stall), 32'd1);
      @(posedge clk); #1;
      t++;
      if (v) i++;
    end
    bus.in_valid = 1'b0;
    if (i < n) check("send_timeout_bytes", 32'(i), 32'(n));
  endtask

  task automatic wait_done(input int seen0);
    int k = 0;
    while (done_cnt == seen0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == seen0) check("done_timeout", 32'(done_cnt), 32'(seen0 + 1));
    @(posedge clk); #1;
  endtask

  task automatic run_load(input logic [11:0] b, input int len, input int nsend,
                          input bit alt, input int pct, input bit inject);
    logic [7:0] cs;
    int         seen0;
    cs = '0;
    for (int i = 0; i < nsend; i++) begin
      logic [11:0] a;
      a = 12'((int'(b) + i) % 4096);
      exp_w.push_back('{addr: a, data: stim[i]});
      ref_mem[a] = stim[i];
      cs = cs + stim[i];
    end
    if (nsend == len) exp_done.push_back('{csum: cs, wr: (len != 0)});
    seen0 = done_cnt;
    do_start(b, len);
    if (len == 0) begin
      @(negedge clk);
      check("done_len0_timing", 32'(done), 32'd1);
      check("len0_no_busy", 32'(busy), 32'd0);
    end
    if (inject) begin
      start = 1'b1;
      base_addr = 12'h123;
      load_len = 13'd5;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_ignored_start", 32'(busy), 32'd1);
    end
    send_bytes(nsend, alt, pct);
    if (nsend == len) wait_done(seen0);
  endtask

  task automatic fill_random(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] b;
    int          len;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    #12;
    mem_init = 1'b1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_waddr", 32'(bus.mem_waddr), 32'd0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // byte stream 13 00 00 00 at address 0 forms a NOP word
    stim = '{8'h13, 8'h00, 8'h00, 8'h00};
    run_load(12'h000, 4, 4, 1'b0, 100, 1'b0);
    cpu_pc = 32'h0; #1;
    check("t1_checksum", 32'(checksum), 32'h13);
    check("t1_word0", cpu_instr, 32'h00000013);

    // wrap from 0xFFF to 0x000
    stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(12'hFFE, 4, 4, 1'b0, 100, 1'b0);
    cpu_pc = 32'h0000_0FFE; #1;
    check("t2_checksum", 32'(checksum), 32'h0E);
    check("t2_word_wrap", cpu_instr, exp_word(cpu_pc));

    // alternating valid
    stim = '{8'h5A, 8'hC3};
    run_load(12'h040, 2, 2, 1'b1, 0, 1'b0);
    cpu_pc = 32'h0000_0040; #1;
    check("t3_passthru", cpu_instr, exp_word(cpu_pc));
    check("t3_not_busy", 32'(busy), 32'd0);

    // oversize length rejected
    exp_err++;
    do_start(12'h000, 4097);
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("t4_err_pulse", 32'(err), 32'd1);
    check("t4_in_ready_idle", 32'(bus.in_ready), 32'd0);
    check("t4_not_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t4_err_one_cycle", 32'(err), 32'd0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // zero length
    stim.delete();
    run_load(12'h100, 0, 0, 1'b0, 100, 1'b0);
    check("t4_len0_checksum", 32'(checksum), 32'd0);

    // start during a load is ignored
    fill_random(8);
    run_load(12'h300, 8, 8, 1'b0, 70, 1'b1);

    // reset after two of eight bytes
    fill_random(8);
    run_load(12'h200, 8, 2, 1'b0, 100, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("t5_rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_checksum", 32'(checksum), 32'd0);
    check("t5_rst_waddr", 32'(bus.mem_waddr), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data = 8'h77;
    repeat (3) begin
      @(posedge clk); #1;
      check("t5_rst_hold_we", 32'(bus.mem_we), 32'd0);
      check("t5_rst_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cpu_pc = 32'h0000_0200; #1;
    check("t5_partial_word", cpu_instr, exp_word(cpu_pc));
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;

    // randomised loads
    for (int r = 0; r < 8; r++) begin
      b = 12'($urandom);
      len = $urandom_range(48, 1);
      fill_random(len);
      run_load(b, len, len, 1'b0, $urandom_range(100, 40), 1'b0);
      cpu_pc = 32'(b); #1;
      check("rand_word", cpu_instr, exp_word(cpu_pc));
    end

    // full-memory load
    b = 12'($urandom);
    fill_random(4096);
    run_load(b, 4096, 4096, 1'b0, 95, 1'b0);
    for (int r = 0; r < 4; r++) begin
      cpu_pc = $urandom; #1;
      check("full_word", cpu_instr, exp_word(cpu_pc));
    end

    repeat (3) @(posedge clk);
    #1;
    check("writes_drained", 32'(exp_w.size()), 32'd0);
    check("dones_drained", 32'(exp_done.size()), 32'd0);
    check("errs_drained", 32'(exp_err), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
